// File: rtl/frame_seq_ctrl_pkg.sv
// Shared configuration for the RGBD visual-odometry frame sequencer:
// FSM encoding, Q24 pose identity, sigma start values and helpers.
package RgbdVoConfigPk;

  localparam int POSE_N = 12;
  localparam int POSE_W = 42;
  localparam int POSE_BITS = POSE_N * POSE_W;

  localparam logic [41:0] POSE_ONE_Q24 = 42'd16777216;
  localparam logic [83:0] SIGMA_ICP_INIT_VAL = 84'd7774054188783816;
  localparam logic [8:0] SIGMA_RGBD_INIT_VAL = 9'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_F_STREAM = 3'd1,
    ST_F_WAIT   = 3'd2,
    ST_D_STREAM = 3'd3,
    ST_D_WAIT   = 3'd4,
    ST_FINISH   = 3'd5
  } seq_state_t;

  // A frame/iteration count of zero behaves as a single pass.
  function automatic logic [3:0] count_eff(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

  // 3x4 pose matrix, row-major: diagonal elements 0, 5 and 10 carry one.
  function automatic logic [POSE_BITS-1:0] pose_identity(input logic [41:0] one);
    logic [POSE_BITS-1:0] p;
    p = '0;
    p[0*POSE_W +: POSE_W]  = one;
    p[5*POSE_W +: POSE_W]  = one;
    p[10*POSE_W +: POSE_W] = one;
    return p;
  endfunction

endpackage

// File: rtl/frame_seq_ctrl_pix_addr_gen.sv
// Pixel read-address generator: after a start pulse, emits npix
// consecutive enabled cycles with addresses 0..npix-1, then stops.
module pix_addr_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start,
  input  logic [18:0] npix,
  output logic        en,
  output logic [18:0] addr,
  output logic        last
);

  // npix of zero is treated as a single-pixel burst so the sequencer never stalls.
  assign last = en && ((addr == npix - 19'd1) || (npix == 19'd0));

  // Burst counter; stops at the final address rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      en   <= 1'b0;
      addr <= '0;
    end else if (start) begin
      en   <= 1'b1;
      addr <= '0;
    end else if (en) begin
      if (last) begin
        en   <= 1'b0;
        addr <= '0;
      end else begin
        addr <= addr + 19'd1;
      end
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer for the odometry core: streams feature frames, then
// runs direct iterations with a lagged reference stream, and holds the
// pose and sigma estimates returned by the core.
module frame_seq_ctrl
  import RgbdVoConfigPk::*;
#(
  parameter logic [41:0] POSE_ONE        = POSE_ONE_Q24,
  parameter logic [83:0] SIGMA_ICP_INIT  = SIGMA_ICP_INIT_VAL,
  parameter logic [8:0]  SIGMA_RGBD_INIT = SIGMA_RGBD_INIT_VAL
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_seq_start,
  input  logic         i_abort,
  input  logic [3:0]   i_n_of_f,
  input  logic [3:0]   i_n_of_d,
  input  logic [18:0]  i_npix,
  input  logic [15:0]  i_ref_delay,
  input  logic         i_feature_ready,
  input  logic         i_done,
  input  logic [503:0] i_pose_new,
  input  logic [83:0]  i_sigma_icp_next,
  input  logic [8:0]   i_sigma_rgbd_next,
  output logic         o_frame_start,
  output logic         o_f_or_d,
  output logic [3:0]   o_frame_idx,
  output logic [3:0]   o_iter_cnt,
  output logic         o_cur_rd_en,
  output logic [18:0]  o_cur_rd_addr,
  output logic         o_ref_rd_en,
  output logic [18:0]  o_ref_rd_addr,
  output logic [503:0] o_pose,
  output logic [83:0]  o_sigma_icp,
  output logic [8:0]   o_sigma_rgbd,
  output logic         o_busy,
  output logic         o_seq_done,
  output logic         o_err
);

  seq_state_t     state_reg;
  logic [3:0]     frame_idx_reg;
  logic [3:0]     iter_reg;
  logic           f_or_d_reg;
  logic           err_reg;
  logic [503:0]   pose_reg;
  logic [83:0]    sigma_icp_reg;
  logic [8:0]     sigma_rgbd_reg;
  logic [15:0]    dly_cnt_reg;
  logic           dly_active_reg;

  logic           more_frames;
  logic           more_iters;
  logic           cur_start;
  logic           d_launch;
  logic           ref_start;
  logic           cur_last;
  logic           ref_last;

  pix_addr_gen u_cur_gen (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (i_abort),
    .start (cur_start),
    .npix  (i_npix),
    .en    (o_cur_rd_en),
    .addr  (o_cur_rd_addr),
    .last  (cur_last)
  );

  pix_addr_gen u_ref_gen (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (i_abort),
    .start (ref_start),
    .npix  (i_npix),
    .en    (o_ref_rd_en),
    .addr  (o_ref_rd_addr),
    .last  (ref_last)
  );

  // Burst launch decisions; the reference burst trails the current one by i_ref_delay.
  always_comb begin
    more_frames = frame_idx_reg < (count_eff(i_n_of_f) - 4'd1);
    more_iters  = iter_reg < (count_eff(i_n_of_d) - 4'd1);
    cur_start   = 1'b0;
    d_launch    = 1'b0;
    if (!i_abort) begin
      case (state_reg)
        ST_IDLE:   cur_start = i_seq_start;
        ST_F_WAIT: begin
          d_launch  = i_done;
          cur_start = i_done || (i_feature_ready && more_frames);
        end
        ST_D_WAIT: begin
          d_launch  = i_done && more_iters;
          cur_start = d_launch;
        end
        default:   cur_start = 1'b0;
      endcase
    end
    ref_start = !i_abort &&
                ((d_launch && (i_ref_delay == 16'd0)) ||
                 (dly_active_reg && (dly_cnt_reg == 16'd1)));
  end

  // Sequencer state, counters, result latches and reference delay counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg      <= ST_IDLE;
      frame_idx_reg  <= '0;
      iter_reg       <= '0;
      f_or_d_reg     <= 1'b0;
      err_reg        <= 1'b0;
      pose_reg       <= pose_identity(POSE_ONE);
      sigma_icp_reg  <= SIGMA_ICP_INIT;
      sigma_rgbd_reg <= SIGMA_RGBD_INIT;
      dly_cnt_reg    <= '0;
      dly_active_reg <= 1'b0;
    end else if (i_abort) begin
      state_reg      <= ST_IDLE;
      f_or_d_reg     <= 1'b0;
      dly_active_reg <= 1'b0;
    end else begin
      if (dly_active_reg) begin
        if (dly_cnt_reg == 16'd1) dly_active_reg <= 1'b0;
        dly_cnt_reg <= dly_cnt_reg - 16'd1;
      end
      if (d_launch && (i_ref_delay != 16'd0)) begin
        dly_cnt_reg    <= i_ref_delay;
        dly_active_reg <= 1'b1;
      end

      // Core handshakes during a stream are protocol violations.
      if (((state_reg == ST_F_STREAM) || (state_reg == ST_D_STREAM)) &&
          (i_done || i_feature_ready))
        err_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: if (i_seq_start) begin
          state_reg     <= ST_F_STREAM;
          frame_idx_reg <= '0;
          iter_reg      <= '0;
          err_reg       <= 1'b0;
        end
        ST_F_STREAM: if (cur_last) state_reg <= ST_F_WAIT;
        ST_F_WAIT: begin
          if (i_done) begin
            pose_reg   <= i_pose_new;
            f_or_d_reg <= 1'b1;
            state_reg  <= ST_D_STREAM;
          end else if (i_feature_ready && more_frames) begin
            frame_idx_reg <= frame_idx_reg + 4'd1;
            state_reg     <= ST_F_STREAM;
          end
        end
        // The reference burst always ends last, so its final beat closes the stream.
        ST_D_STREAM: if (ref_last) state_reg <= ST_D_WAIT;
        ST_D_WAIT: if (i_done) begin
          pose_reg       <= i_pose_new;
          sigma_icp_reg  <= i_sigma_icp_next;
          sigma_rgbd_reg <= i_sigma_rgbd_next;
          if (more_iters) begin
            iter_reg  <= iter_reg + 4'd1;
            state_reg <= ST_D_STREAM;
          end else begin
            state_reg <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          f_or_d_reg <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_frame_start = o_cur_rd_en && (o_cur_rd_addr == 19'd0);
  assign o_f_or_d      = f_or_d_reg;
  assign o_frame_idx   = frame_idx_reg;
  assign o_iter_cnt    = iter_reg;
  assign o_pose        = pose_reg;
  assign o_sigma_icp   = sigma_icp_reg;
  assign o_sigma_rgbd  = sigma_rgbd_reg;
  assign o_busy        = (state_reg != ST_IDLE);
  assign o_seq_done    = (state_reg == ST_FINISH);
  assign o_err         = err_reg;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl: a table of sequence configurations
// with hand-computed burst totals, plus corner-case sequences.
module tb_frame_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst_n, seq_start, abort, feature_ready, done;
  logic [3:0]   n_of_f, n_of_d, frame_idx, iter_cnt;
  logic [18:0]  npix, cur_addr, ref_addr;
  logic [15:0]  ref_delay;
  logic [503:0] pose_new, pose;
  logic [83:0]  sigma_icp_next, sigma_icp;
  logic [8:0]   sigma_rgbd_next, sigma_rgbd;
  logic         frame_start, f_or_d, cur_en, ref_en, busy, seq_done, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  frame_seq_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_seq_start(seq_start), .i_abort(abort),
    .i_n_of_f(n_of_f), .i_n_of_d(n_of_d), .i_npix(npix), .i_ref_delay(ref_delay),
    .i_feature_ready(feature_ready), .i_done(done), .i_pose_new(pose_new),
    .i_sigma_icp_next(sigma_icp_next), .i_sigma_rgbd_next(sigma_rgbd_next),
    .o_frame_start(frame_start), .o_f_or_d(f_or_d), .o_frame_idx(frame_idx),
    .o_iter_cnt(iter_cnt), .o_cur_rd_en(cur_en), .o_cur_rd_addr(cur_addr),
    .o_ref_rd_en(ref_en), .o_ref_rd_addr(ref_addr), .o_pose(pose),
    .o_sigma_icp(sigma_icp), .o_sigma_rgbd(sigma_rgbd), .o_busy(busy),
    .o_seq_done(seq_done), .o_err(err)
  );

  // Stream monitor, sampled on the falling edge.
  int cyc = 0, cur_cnt = 0, ref_cnt = 0, fs_cnt = 0, fs_bad = 0;
  int addr_bad = 0, lag_bad = 0, done_cnt = 0, last_cur0 = 0, exp_lag = 0;
  logic [18:0] exp_cur = '0, exp_ref = '0;

  always @(negedge clk) begin
    cyc++;
    if (cur_en) begin
      cur_cnt++;
      if (cur_addr != exp_cur) addr_bad++;
      if (cur_addr == 19'd0) last_cur0 = cyc;
      exp_cur = cur_addr + 19'd1;
    end else exp_cur = '0;
    if (ref_en) begin
      ref_cnt++;
      if (ref_addr != exp_ref) addr_bad++;
      if (ref_addr == 19'd0 && (cyc - last_cur0) != exp_lag) lag_bad++;
      exp_ref = ref_addr + 19'd1;
    end else exp_ref = '0;
    if (frame_start) begin
      fs_cnt++;
      if (!(cur_en && cur_addr == 19'd0)) fs_bad++;
    end
    if (seq_done) done_cnt++;
  end

  task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else $display("ok   %s = %0d", name, act);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    seq_start = 1'b1; step(1); seq_start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1; step(1); done = 1'b0;
  endtask

  task automatic pulse_ready();
    feature_ready = 1'b1; step(1); feature_ready = 1'b0;
  endtask

  function automatic logic [41:0] el(input logic [503:0] p, input int k);
    return p[k*42 +: 42];
  endfunction

  // Wait until the monitor has seen the given enable totals and both streams are idle.
  task automatic wait_streams(input int cur_t, input int ref_t, input string name);
    int n = 0;
    while (!(cur_cnt >= cur_t && ref_cnt >= ref_t && !cur_en && !ref_en) && n < 3000) begin
      step(1); n++;
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL %s timeout: cur=%0d ref=%0d, required cur=%0d ref=%0d", name, cur_cnt, ref_cnt, cur_t, ref_t);
    end
    step(2);
  endtask

  task automatic wait_addr(input logic [18:0] a, input string name);
    int n = 0;
    while (!(cur_en && cur_addr == a) && n < 500) begin step(1); n++; end
    if (n >= 500) begin
      tests++; fails++;
      $display("FAIL %s timeout waiting for cur address %0d, got %0d", name, a, cur_addr);
    end
  endtask

  typedef struct {
    int npix; logic [3:0] nf; logic [3:0] nd; int delay;
    int nfe; int nde; int exp_cur; int exp_ref; int exp_fs;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int b_cur, b_ref, b_fs, b_done, b_lag, b_addr, b_fsbad;
    vecs[0] = '{16, 4'd2, 4'd3, 5, 2, 3, 80, 48, 5};
    vecs[1] = '{8,  4'd0, 4'd0, 0, 1, 1, 16, 8,  2};
    vecs[2] = '{4,  4'd1, 4'd2, 9, 1, 2, 12, 8,  3};
    vecs[3] = '{1,  4'd3, 4'd1, 2, 3, 1, 4,  1,  4};

    rst_n = 1'b0; seq_start = 0; abort = 0; feature_ready = 0; done = 0;
    n_of_f = 4'd1; n_of_d = 4'd1; npix = 19'd16; ref_delay = 16'd0;
    pose_new = '0; sigma_icp_next = '0; sigma_rgbd_next = '0;
    step(3);
    rst_n = 1'b1;
    step(1);

    check("reset busy", busy, 0);
    check("reset cur_en", cur_en, 0);
    check("reset ref_en", ref_en, 0);
    check("reset pose0", el(pose, 0), 42'd16777216);
    check("reset pose5", el(pose, 5), 42'd16777216);
    check("reset pose1", el(pose, 1), 0);
    check("reset sigma_icp", sigma_icp, 84'd7774054188783816);
    check("reset sigma_rgbd", sigma_rgbd, 9'd5);
    check("reset err", err, 0);

    // Table of full sequences.
    for (int v = 0; v < 4; v++) begin
      npix = vecs[v].npix[18:0]; n_of_f = vecs[v].nf; n_of_d = vecs[v].nd;
      ref_delay = vecs[v].delay[15:0]; exp_lag = vecs[v].delay;
      b_cur = cur_cnt; b_ref = ref_cnt; b_fs = fs_cnt; b_done = done_cnt;
      b_lag = lag_bad; b_addr = addr_bad; b_fsbad = fs_bad;
      pulse_start();
      check($sformatf("v%0d busy after start", v), busy, 1);
      for (int f = 0; f < vecs[v].nfe; f++) begin
        wait_streams(b_cur + (f + 1) * vecs[v].npix, b_ref, $sformatf("v%0d feature %0d", v, f));
        check($sformatf("v%0d frame_idx %0d", v, f), frame_idx, f);
        if (f < vecs[v].nfe - 1) pulse_ready();
        else begin
          pose_new[3*42 +: 42] = 42'd500;
          pulse_done();
          check($sformatf("v%0d f_or_d after done", v), f_or_d, 1);
          check($sformatf("v%0d pose3 feature latch", v), el(pose, 3), 500);
        end
      end
      for (int d = 0; d < vecs[v].nde; d++) begin
        wait_streams(b_cur + (vecs[v].nfe + d + 1) * vecs[v].npix,
                     b_ref + (d + 1) * vecs[v].npix, $sformatf("v%0d direct %0d", v, d));
        check($sformatf("v%0d iter_cnt %0d", v, d), iter_cnt, d);
        pose_new[3*42 +: 42] = 42'd1000 + 42'(d);
        sigma_rgbd_next = 9'd7 + 9'(d);
        sigma_icp_next = 84'd123456789 + 84'(v);
        pulse_done();
        check($sformatf("v%0d pose3 iter %0d", v, d), el(pose, 3), 1000 + d);
        check($sformatf("v%0d sigma_rgbd iter %0d", v, d), sigma_rgbd, 7 + d);
        check($sformatf("v%0d sigma_icp iter %0d", v, d), sigma_icp, 123456789 + v);
      end
      check($sformatf("v%0d seq_done in finish", v), seq_done, 1);
      step(2);
      check($sformatf("v%0d busy at end", v), busy, 0);
      check($sformatf("v%0d f_or_d at end", v), f_or_d, 0);
      check($sformatf("v%0d cur enables", v), cur_cnt - b_cur, vecs[v].exp_cur);
      check($sformatf("v%0d ref enables", v), ref_cnt - b_ref, vecs[v].exp_ref);
      check($sformatf("v%0d frame starts", v), fs_cnt - b_fs, vecs[v].exp_fs);
      check($sformatf("v%0d stray frame starts", v), fs_bad - b_fsbad, 0);
      check($sformatf("v%0d seq_done pulses", v), done_cnt - b_done, 1);
      check($sformatf("v%0d ref lag errors", v), lag_bad - b_lag, 0);
      check($sformatf("v%0d address errors", v), addr_bad - b_addr, 0);
      check($sformatf("v%0d err", v), err, 0);
    end

    // i_done during D_STREAM: error flagged, stream completes, pose untouched.
    npix = 19'd16; n_of_f = 4'd1; n_of_d = 4'd1; ref_delay = 16'd3; exp_lag = 3;
    b_cur = cur_cnt; b_ref = ref_cnt; b_addr = addr_bad;
    pulse_start();
    wait_streams(b_cur + 16, b_ref, "mid feature");
    pose_new[3*42 +: 42] = 42'd555;
    pulse_done();
    check("mid pose3 latched", el(pose, 3), 555);
    wait_addr(19'd5, "mid");
    pose_new[3*42 +: 42] = 42'd999;
    pulse_done();
    check("mid err set", err, 1);
    check("mid stream continues", cur_en, 1);
    wait_streams(b_cur + 32, b_ref + 16, "mid direct");
    check("mid cur enables", cur_cnt - b_cur, 32);
    check("mid address errors", addr_bad - b_addr, 0);
    check("mid pose3 unchanged", el(pose, 3), 555);
    check("mid busy in D_WAIT", busy, 1);
    sigma_rgbd_next = 9'd21;
    pulse_done();
    check("mid err sticky", err, 1);
    step(2);

    // Abort at address 7, then restart from address 0.
    pulse_start();
    check("abort err cleared by start", err, 0);
    wait_addr(19'd7, "abort");
    abort = 1'b1; step(1); abort = 1'b0;
    check("abort cur_en", cur_en, 0);
    check("abort frame_start", frame_start, 0);
    check("abort busy", busy, 0);
    check("abort pose3 kept", el(pose, 3), 999);
    check("abort sigma_rgbd kept", sigma_rgbd, 21);
    pulse_start();
    check("restart cur_en", cur_en, 1);
    check("restart addr", cur_addr, 0);
    check("restart frame_start", frame_start, 1);
    abort = 1'b1; step(1); abort = 1'b0;

    // Reset in the middle of D_STREAM.
    ref_delay = 16'd0; exp_lag = 0;
    b_cur = cur_cnt;
    pulse_start();
    wait_streams(b_cur + 16, ref_cnt, "reset feature");
    for (int k = 0; k < 12; k++) pose_new[k*42 +: 42] = 42'd77;
    pulse_done();
    check("rst pre pose0", el(pose, 0), 77);
    wait_addr(19'd4, "rst");
    check("rst pre ref_en", ref_en, 1);
    rst_n = 1'b0; abort = 1'b1; step(1);
    check("rst cur_en", cur_en, 0);
    check("rst ref_en", ref_en, 0);
    check("rst frame_start", frame_start, 0);
    check("rst busy", busy, 0);
    check("rst pose0", el(pose, 0), 42'd16777216);
    check("rst pose3", el(pose, 3), 0);
    check("rst sigma_rgbd", sigma_rgbd, 5);
    check("rst sigma_icp", sigma_icp, 84'd7774054188783816);
    rst_n = 1'b1; abort = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
